// File: rtl/threshold_monitor.sv
// Hysteretic alarm driven by 4-bit magnitude comparator flags (a = sample, b = threshold).
// Consecutive greater/less runs raise/drop a registered alarm; equal samples are neutral.
module threshold_monitor #(
    parameter int CNT_W        = 4,
    parameter int ASSERT_CNT   = 3,
    parameter int DEASSERT_CNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a_greater,
    input  logic             a_equal,
    input  logic             a_less,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic             flag_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] run_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMING   = 2'd1,
        ALARM    = 2'd2,
        CLEARING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ASSERT_LIM   = CNT_W'(ASSERT_CNT);
    localparam logic [CNT_W-1:0] DEASSERT_LIM = CNT_W'(DEASSERT_CNT);

    if (CNT_W < 2 || CNT_W > 8) begin : g_bad_cnt_w
        $error("threshold_monitor: CNT_W must be in 2..8");
    end
    if (ASSERT_CNT < 1 || ASSERT_CNT > (1 << CNT_W) - 1) begin : g_bad_assert
        $error("threshold_monitor: ASSERT_CNT out of range for CNT_W");
    end
    if (DEASSERT_CNT < 1 || DEASSERT_CNT > (1 << CNT_W) - 1) begin : g_bad_deassert
        $error("threshold_monitor: DEASSERT_CNT out of range for CNT_W");
    end

    state_t           state_p1, state_nxt;
    logic [CNT_W-1:0] cnt_p1, cnt_nxt, cnt_inc;
    logic             alarm_p1, rise_p1, fall_p1, err_p1;
    logic             rise_nxt, fall_nxt, err_nxt;
    logic [2:0]       flags;
    logic             one_hot;

    assign flags   = {a_greater, a_equal, a_less};
    assign one_hot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    assign cnt_inc = cnt_p1 + CNT_ONE;

    always_comb begin
        state_nxt = state_p1;
        cnt_nxt   = cnt_p1;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (in_valid) begin
            if (!one_hot) begin
                err_nxt = 1'b1;
            end else begin
                // Equal samples fall through every branch below and leave the run intact.
                case (state_p1)
                    IDLE: begin
                        if (a_greater) begin
                            if (ASSERT_CNT == 1) begin
                                state_nxt = ALARM;
                                cnt_nxt   = '0;
                                rise_nxt  = 1'b1;
                            end else begin
                                state_nxt = ARMING;
                                cnt_nxt   = CNT_ONE;
                            end
                        end else if (a_less) begin
                            cnt_nxt = '0;
                        end
                    end
                    ARMING: begin
                        if (a_greater) begin
                            if (cnt_inc == ASSERT_LIM) begin
                                state_nxt = ALARM;
                                cnt_nxt   = '0;
                                rise_nxt  = 1'b1;
                            end else begin
                                cnt_nxt = cnt_inc;
                            end
                        end else if (a_less) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end
                    ALARM: begin
                        if (a_greater) begin
                            cnt_nxt = '0;
                        end else if (a_less) begin
                            if (DEASSERT_CNT == 1) begin
                                state_nxt = IDLE;
                                cnt_nxt   = '0;
                                fall_nxt  = 1'b1;
                            end else begin
                                state_nxt = CLEARING;
                                cnt_nxt   = CNT_ONE;
                            end
                        end
                    end
                    CLEARING: begin
                        if (a_less) begin
                            if (cnt_inc == DEASSERT_LIM) begin
                                state_nxt = IDLE;
                                cnt_nxt   = '0;
                                fall_nxt  = 1'b1;
                            end else begin
                                cnt_nxt = cnt_inc;
                            end
                        end else if (a_greater) begin
                            state_nxt = ALARM;
                            cnt_nxt   = '0;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    // Output register stage: every port is driven from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= IDLE;
            cnt_p1   <= '0;
            alarm_p1 <= 1'b0;
            rise_p1  <= 1'b0;
            fall_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            cnt_p1   <= cnt_nxt;
            alarm_p1 <= (state_nxt == ALARM) || (state_nxt == CLEARING);
            rise_p1  <= rise_nxt;
            fall_p1  <= fall_nxt;
            err_p1   <= err_nxt;
        end
    end

    assign state      = state_p1;
    assign run_cnt    = cnt_p1;
    assign alarm      = alarm_p1;
    assign alarm_rise = rise_p1;
    assign alarm_fall = fall_p1;
    assign flag_err   = err_p1;

endmodule

// File: doc/threshold_monitor.md
Name: threshold_monitor

Overview:
- Sits directly downstream of the 4-bit magnitude comparator and consumes its `a_greater` / `a_equal` / `a_less` flags. Comparator operand a is the sample and b is the threshold.
- Applies count-based hysteresis:
  - Raises `alarm` after ASSERT_CNT consecutive valid "greater" results.
  - Drops `alarm` after DEASSERT_CNT consecutive valid "less" results.
- Provides a clean, glitch-free, registered alarm for control logic and the status LEDs.

Parameters:
- CNT_W, 4, width of the run counter. Legal: 2..8.
- ASSERT_CNT, 3, consecutive greater samples needed to raise alarm. Legal: 1..2^CNT_W-1.
- DEASSERT_CNT, 3, consecutive less samples needed to drop alarm. Legal: 1..2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  comparator flags are a valid sample this cycle.
- a_greater  input  1  comparator flag, a > b.
- a_equal  input  1  comparator flag, a == b.
- a_less  input  1  comparator flag, a < b.
- alarm  output  1  registered hysteretic alarm level.
- alarm_rise  output  1  one-cycle pulse on the cycle alarm goes 0→1.
- alarm_fall  output  1  one-cycle pulse on the cycle alarm goes 1→0.
- flag_err  output  1  one-cycle pulse: valid sample whose flags were not one-hot.
- state  output  2  FSM state: IDLE=0, ARMING=1, ALARM=2, CLEARING=3.
- run_cnt  output  CNT_W  current consecutive-sample count.

Behaviour:
- Reset: One clock; reset is asynchronous and active-low, ports `clk` and `rst_n`. While `rst_n`=0, all outputs are 0 and state=IDLE, independent of clk.
- Output registering: All outputs are registered. The response to a sample accepted at edge N is visible after edge N, so latency is 1 cycle.
- Accepting a sample: A sample is consumed only when `in_valid`=1 at the rising edge. With `in_valid`=0, state and `run_cnt` hold and all pulses are 0.
- Flag check: Flags must be one-hot.
  - If a valid sample's flags are not one-hot (000, 011, 110, 111, ...), pulse `flag_err`.
  - That sample is otherwise ignored: state and `run_cnt` are unchanged.
- Equal results: A valid "equal" sample is neutral in every state. State and `run_cnt` hold, and it does not break a run.
- FSM transitions for valid, one-hot samples:
  - IDLE:
    - greater: if ASSERT_CNT=1, go to ALARM (alarm=1, alarm_rise=1, run_cnt=0); otherwise go to ARMING with run_cnt=1.
    - less: stay in IDLE, run_cnt=0.
  - ARMING:
    - greater: if run_cnt+1 == ASSERT_CNT, go to ALARM with alarm=1, alarm_rise=1, run_cnt=0; otherwise run_cnt += 1.
    - less: go to IDLE, run_cnt=0.
  - ALARM:
    - greater: stay, run_cnt=0.
    - less: if DEASSERT_CNT=1, go to IDLE (alarm=0, alarm_fall=1, run_cnt=0); otherwise go to CLEARING with run_cnt=1.
  - CLEARING:
    - less: if run_cnt+1 == DEASSERT_CNT, go to IDLE with alarm=0, alarm_fall=1, run_cnt=0; otherwise run_cnt += 1.
    - greater: go to ALARM, run_cnt=0, alarm stays 1 with no pulses.
- Alarm level: `alarm` is 1 exactly in ALARM and CLEARING.
- Pulse exclusivity: `alarm_rise` and `alarm_fall` are never high in the same cycle. `flag_err` is never high together with either of them.
- Counter range: `run_cnt` never exceeds max(ASSERT_CNT, DEASSERT_CNT)-1, so no overflow or wrap logic is needed. Parameter legality is checked at elaboration.
- Reset mid-run: Asserting `rst_n` mid-run (e.g. in ARMING with run_cnt=2) clears state immediately. The first valid sample after release is treated as the first sample of a new run.

Test Plan:
1. Reset: hold rst_n=0, toggle flags with in_valid=1 → all outputs 0, state=0. Release → outputs stay 0 until the first valid sample.
2. Assert path: three valid greater samples (a=8, b=6) on consecutive edges → run_cnt 1, 2, then alarm=1, state=2, run_cnt=0, a single-cycle alarm_rise on the third edge.
3. Broken run: greater, greater, less (a=6, b=8) → state 1, 1, 0; run_cnt 1, 2, 0; alarm never rises; no pulses.
4. Deassert with equal: from ALARM apply less, equal (a=8, b=8), less, less → state 3, 3, 3, 0; run_cnt 1, 1, 2, 0; alarm falls after the 4th sample with a single alarm_fall. Repeat with less, greater → back to state 2, no pulses.
5. Qualifiers: in_valid=0 with a_greater=1 for 5 cycles → no change. Valid flags 3'b110 (greater, equal) → flag_err pulse, state and run_cnt unchanged.
6. Async reset: in ARMING with run_cnt=2, drop rst_n between clock edges → state and run_cnt=0 before the next edge. After release, 3 greater samples are needed again for alarm=1.
